// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered active-low reset release (hold, wait for ready, staggered stages, done pulse)
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8,
  parameter int CNT_W       = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  rst_req,
  input  logic                  ext_ready,
  output logic [NUM_STAGES-1:0] aresetn_out,
  output logic                  busy,
  output logic                  done
);
  localparam int IDX_W = $clog2(NUM_STAGES + 1);
  typedef enum logic [1:0] {S_ASSERT, S_WAIT_READY, S_RELEASE, S_RUN} state_t;
  state_t                r_state, w_state;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [IDX_W-1:0]      r_idx, w_idx;
  logic [NUM_STAGES-1:0] r_rstn, w_rstn;
  logic [1:0]            r_sync;
  logic                  r_busy, r_done, w_done, w_rdy;
  assign w_rdy       = r_sync[1];
  assign aresetn_out = r_rstn;
  assign busy        = r_busy;
  assign done        = r_done;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_state <= S_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rstn  <= '0;
      r_sync  <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_rstn  <= w_rstn;
      r_sync  <= {r_sync[0], ext_ready};
      r_busy  <= w_state != S_RUN;
      r_done  <= w_done;
    end
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 1'b1;
    w_idx   = r_idx;
    w_rstn  = r_rstn;
    w_done  = 1'b0;
    case (r_state)
      S_ASSERT:
        if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          w_state = S_WAIT_READY;
          w_cnt   = '0;
        end
      S_WAIT_READY: begin
        w_cnt = '0;
        if (w_rdy) begin
          w_state = S_RELEASE;
          w_rstn  = NUM_STAGES'(1);
          w_idx   = IDX_W'(1);
        end
      end
      S_RELEASE:
        if (r_cnt == CNT_W'(STAGE_DELAY - 1)) begin
          w_cnt = '0;
          if (r_idx == IDX_W'(NUM_STAGES)) begin
            w_state = S_RUN;
            w_done  = 1'b1;
          end else begin
            w_rstn = r_rstn | (NUM_STAGES'(1) << r_idx);
            w_idx  = r_idx + 1'b1;
          end
        end
      S_RUN: w_cnt = '0;
      default: w_state = S_ASSERT;
    endcase
    // soft request always wins; lock loss only aborts once outputs may be released
    if (rst_req || (!w_rdy && (r_state == S_RELEASE || r_state == S_RUN))) begin
      w_state = S_ASSERT;
      w_cnt   = '0;
      w_idx   = '0;
      w_rstn  = '0;
      w_done  = 1'b0;
    end
  end
endmodule
